// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the UART_TX FIFO write port between N_REQ byte-stream requesters.
// A grant covers a whole packet and is withdrawn early on burst overrun or a stalled owner.
module uart_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  input  logic               fifo_full,
  output logic               tx_write,
  output logic [7:0]         tx_data,
  output logic [N_REQ-1:0]   grant,
  output logic               busy,
  output logic [N_REQ-1:0]   timeout_err,
  output logic [N_REQ-1:0]   burst_err
);

  localparam int IW = $clog2(N_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] BURST_MAX  = BW'(MAX_BURST);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [TW-1:0] IDLE_MAX   = TW'(TIMEOUT);
  localparam logic [TW-1:0] IDLE_LAST  = TW'(TIMEOUT - 1);
  localparam logic [IW-1:0] PTR_RST    = IW'(N_REQ - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [BW-1:0]    burst_cnt_q, burst_cnt_d;
  logic [TW-1:0]    idle_cnt_q, idle_cnt_d;
  logic [N_REQ-1:0] timeout_err_q, timeout_err_d;
  logic [N_REQ-1:0] burst_err_q, burst_err_d;

  logic          pick_found_s;
  logic [IW-1:0] pick_idx_s;
  logic          xfer_s;
  logic          sel_valid_s;
  logic          sel_last_s;
  logic [7:0]    sel_data_s;
  logic          accept_s;

  // Scanning downwards leaves the first valid requester after the pointer as the winner.
  always_comb begin
    int j;
    j            = 0;
    pick_found_s = 1'b0;
    pick_idx_s   = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      j = int'(ptr_q) + k;
      if (j >= N_REQ) begin
        j = j - N_REQ;
      end else begin
        j = j;
      end
      if (req_valid[j]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = IW'(j);
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  assign xfer_s      = (state_q == ST_XFER);
  assign sel_valid_s = req_valid[idx_q];
  assign sel_last_s  = req_last[idx_q];
  assign sel_data_s  = req_data[{idx_q, 3'b000} +: 8];
  assign accept_s    = xfer_s & sel_valid_s & ~fifo_full;

  // Write-side handshake is combinational so the accept and the FIFO write share a cycle.
  always_comb begin
    req_ready = '0;
    tx_write  = accept_s;
    tx_data   = 8'h00;
    if (xfer_s && !fifo_full) begin
      req_ready = grant_q;
    end else begin
      req_ready = '0;
    end
    if (accept_s) begin
      tx_data = sel_data_s;
    end else begin
      tx_data = 8'h00;
    end
  end

  assign grant       = grant_q;
  assign busy        = xfer_s;
  assign timeout_err = timeout_err_q;
  assign burst_err   = burst_err_q;

  // Next-state logic: arbitration in IDLE, packet/burst/stall release rules in XFER.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    idx_d         = idx_q;
    ptr_d         = ptr_q;
    burst_cnt_d   = burst_cnt_q;
    idle_cnt_d    = idle_cnt_q;
    timeout_err_d = '0;
    burst_err_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found_s) begin
          state_d             = ST_XFER;
          idx_d               = pick_idx_s;
          grant_d             = '0;
          grant_d[pick_idx_s] = 1'b1;
          burst_cnt_d         = '0;
          idle_cnt_d          = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (accept_s) begin
          idle_cnt_d = '0;
          if (burst_cnt_q != BURST_MAX) begin
            burst_cnt_d = burst_cnt_q + 1'b1;
          end else begin
            burst_cnt_d = burst_cnt_q;
          end
          if (sel_last_s) begin
            state_d = ST_IDLE;
            grant_d = '0;
            ptr_d   = idx_q;
          end else if (burst_cnt_q == BURST_LAST) begin
            state_d            = ST_IDLE;
            grant_d            = '0;
            ptr_d              = idx_q;
            burst_err_d[idx_q] = 1'b1;
          end else begin
            state_d = ST_XFER;
          end
        end else if (!sel_valid_s && !fifo_full) begin
          // Only the owner going quiet counts; a full FIFO is our own stall.
          if (idle_cnt_q != IDLE_MAX) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end else begin
            idle_cnt_d = idle_cnt_q;
          end
          if (idle_cnt_q == IDLE_LAST) begin
            state_d              = ST_IDLE;
            grant_d              = '0;
            ptr_d                = idx_q;
            timeout_err_d[idx_q] = 1'b1;
          end else begin
            state_d = ST_XFER;
          end
        end else begin
          state_d = ST_XFER;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State and counter registers; reset drops any grant immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      idx_q         <= '0;
      ptr_q         <= PTR_RST;
      burst_cnt_q   <= '0;
      idle_cnt_q    <= '0;
      timeout_err_q <= '0;
      burst_err_q   <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      idx_q         <= idx_d;
      ptr_q         <= ptr_d;
      burst_cnt_q   <= burst_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      timeout_err_q <= timeout_err_d;
      burst_err_q   <= burst_err_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios followed by random traffic,
// all compared cycle by cycle against a packet-level reference model.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int MB = 16;
  localparam int TO = 64;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready;
  logic           fifo_full = 1'b0;
  logic           tx_write;
  logic [7:0]     tx_data;
  logic [N-1:0]   grant;
  logic           busy;
  logic [N-1:0]   timeout_err;
  logic [N-1:0]   burst_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .MAX_BURST(MB), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_full(fifo_full),
    .tx_write(tx_write), .tx_data(tx_data), .grant(grant), .busy(busy),
    .timeout_err(timeout_err), .burst_err(burst_err)
  );

  int n_assert = 0;
  int n_fail = 0;

  // Per-requester byte queues: bit 8 is the last flag.
  logic [8:0] srcq [N][$];
  logic [N-1:0] en = '0;
  logic full_s = 1'b0;

  // Reference model: owner of the line (-1 = nobody) and packet bookkeeping.
  int m_owner, m_ptr, m_cnt, m_idle, acc_idx;
  logic [N-1:0] m_terr, m_berr;

  logic [7:0] obs_log[$];
  int tick_no = 0;
  int last_wr_tick = 0;
  int o_tick = 0;
  logic [N-1:0] o_grant, o_berr, o_terr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (tick %0d)", tag, obs, exp, tick_no);
    end
  endtask

  function automatic void model_reset();
    m_owner = -1; m_ptr = N - 1; m_cnt = 0; m_idle = 0;
    m_terr = '0; m_berr = '0; acc_idx = -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (en[i] && srcq[i].size() > 0) begin
        req_valid[i]       = 1'b1;
        req_data[i*8 +: 8] = srcq[i][0][7:0];
        req_last[i]        = srcq[i][0][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[i*8 +: 8] = 8'($urandom);
        req_last[i]        = 1'($urandom);
      end
    end
    fifo_full = full_s;
  endtask

  task automatic check();
    logic [N-1:0] eg, er;
    logic ew;
    logic [7:0] ed;
    eg = '0; er = '0; ew = 1'b0; ed = 8'h00;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      if (!fifo_full) er[m_owner] = 1'b1;
      if (req_valid[m_owner] && !fifo_full) begin
        ew = 1'b1;
        ed = req_data[m_owner*8 +: 8];
      end
    end
    chk("grant", 32'(grant), 32'(eg));
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("tx_write", 32'(tx_write), 32'(ew));
    chk("tx_data", 32'(tx_data), 32'(ed));
    chk("busy", 32'(busy), (m_owner >= 0) ? 32'd1 : 32'd0);
    chk("timeout_err", 32'(timeout_err), 32'(m_terr));
    chk("burst_err", 32'(burst_err), 32'(m_berr));
    chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
    o_grant = grant; o_berr = burst_err; o_terr = timeout_err; o_tick = tick_no;
    if (tx_write === 1'b1) begin
      obs_log.push_back(tx_data);
      last_wr_tick = tick_no;
    end
  endtask

  task automatic model_step();
    int o;
    logic [N-1:0] nt, nb;
    nt = '0; nb = '0; acc_idx = -1; o = m_owner;
    if (o < 0) begin
      for (int k = 1; k <= N; k++) begin
        if (m_owner < 0 && req_valid[(m_ptr + k) % N]) begin
          m_owner = (m_ptr + k) % N; m_cnt = 0; m_idle = 0;
        end
      end
    end else if (req_valid[o] && !fifo_full) begin
      acc_idx = o; m_cnt++; m_idle = 0;
      if (req_last[o]) begin
        m_ptr = o; m_owner = -1;
      end else if (m_cnt == MB) begin
        nb[o] = 1'b1; m_ptr = o; m_owner = -1;
      end
    end else if (!req_valid[o] && !fifo_full) begin
      m_idle++;
      if (m_idle == TO) begin
        nt[o] = 1'b1; m_ptr = o; m_owner = -1;
      end
    end
    m_terr = nt; m_berr = nb;
  endtask

  task automatic tick();
    drive();
    @(negedge clk);
    check();
    model_step();
    @(posedge clk);
    #1;
    if (acc_idx >= 0) void'(srcq[acc_idx].pop_front());
    tick_no++;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0; full_s = 1'b0; en = '0;
    for (int i = 0; i < N; i++) srcq[i].delete();
    drive();
    model_reset();
    #1;
    check();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    obs_log.delete();
  endtask

  initial begin
    logic [N-1:0] cap, prev, first_g;
    logic [N-1:0] order[$];
    int wr_before, seen, len;
    logic [7:0] exp3[3];
    logic [7:0] exp5[5];

    model_reset();
    do_reset();

    // Single three-byte packet from requester 0.
    en = '1;
    srcq[0].push_back({1'b0, 8'hA1});
    srcq[0].push_back({1'b0, 8'hA2});
    srcq[0].push_back({1'b1, 8'hA3});
    repeat (8) tick();
    exp3[0] = 8'hA1; exp3[1] = 8'hA2; exp3[2] = 8'hA3;
    chk("pkt0_count", 32'(obs_log.size()), 32'd3);
    for (int i = 0; i < 3 && i < obs_log.size(); i++) chk("pkt0_byte", 32'(obs_log[i]), 32'(exp3[i]));

    // All requesters with single-byte packets: strict rotation, two cycles per packet.
    do_reset();
    en = '1;
    for (int i = 0; i < N; i++) begin
      srcq[i].push_back({1'b1, 8'(8'h40 + i)});
      srcq[i].push_back({1'b1, 8'(8'h50 + i)});
    end
    prev = '0;
    repeat (16) begin
      tick();
      if (o_grant != 0 && prev == 0) order.push_back(o_grant);
      prev = o_grant;
    end
    chk("rr_writes_16cyc", 32'(obs_log.size()), 32'd8);
    chk("rr_grants", 32'(order.size()), 32'd8);
    for (int i = 0; i < 5 && i < order.size(); i++) chk("rr_order", 32'(order[i]), 32'(4'b0001 << (i % 4)));

    // Requester 1 overruns MAX_BURST; requester 2 must win next.
    do_reset();
    en = 4'b0110;
    for (int k = 0; k < 20; k++) srcq[1].push_back({1'b0, 8'(k)});
    srcq[2].push_back({1'b1, 8'hC2});
    seen = 0; wr_before = 0; cap = '0; first_g = '0;
    repeat (30) begin
      tick();
      if (seen == 0) begin
        if (o_berr != 0) begin
          seen = 1; cap = o_berr; wr_before = obs_log.size();
        end
      end else if (first_g == 0 && o_grant != 0) begin
        first_g = o_grant;
      end
    end
    chk("burst_err_seen", 32'(cap), 32'(4'b0010));
    chk("burst_writes", 32'(wr_before), 32'(MB));
    chk("burst_next_grant", 32'(first_g), 32'(4'b0100));

    // Requester 2 goes quiet after one byte: timeout exactly TIMEOUT idle cycles later.
    do_reset();
    en = 4'b0100;
    srcq[2].push_back({1'b0, 8'h77});
    seen = 0; cap = '0; wr_before = 0;
    repeat (80) begin
      tick();
      if (seen == 0 && o_terr != 0) begin
        seen = 1; cap = o_terr; wr_before = o_tick - last_wr_tick;
      end
    end
    chk("timeout_err_seen", 32'(cap), 32'(4'b0100));
    chk("timeout_latency", 32'(wr_before), 32'(TO + 1));

    // FIFO full for 10 cycles mid-packet.
    do_reset();
    en = 4'b0001;
    for (int k = 0; k < 5; k++) srcq[0].push_back({(k == 4) ? 1'b1 : 1'b0, 8'(8'h10 + k)});
    for (int t = 0; t < 20; t++) begin
      full_s = (t >= 3 && t < 13);
      tick();
    end
    full_s = 1'b0;
    for (int k = 0; k < 5; k++) exp5[k] = 8'(8'h10 + k);
    chk("full_count", 32'(obs_log.size()), 32'd5);
    for (int i = 0; i < 5 && i < obs_log.size(); i++) chk("full_byte", 32'(obs_log[i]), 32'(exp5[i]));

    // Asynchronous reset during a transfer.
    do_reset();
    en = 4'b1000;
    for (int k = 0; k < 10; k++) srcq[3].push_back({1'b0, 8'(8'h30 + k)});
    srcq[0].push_back({1'b1, 8'h5A});
    repeat (3) tick();
    drive();
    #2;
    chk("rst_pre_write", 32'(tx_write), 32'd1);
    chk("rst_pre_grant", 32'(grant), 32'(4'b1000));
    reset_n = 1'b0;
    #1;
    chk("rst_async_grant", 32'(grant), 32'd0);
    chk("rst_async_write", 32'(tx_write), 32'd0);
    chk("rst_async_busy", 32'(busy), 32'd0);
    chk("rst_async_ready", 32'(req_ready), 32'd0);
    model_reset();
    en = 4'b1001;
    drive();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    obs_log.delete();
    first_g = '0;
    repeat (4) begin
      tick();
      if (first_g == 0 && o_grant != 0) first_g = o_grant;
    end
    chk("rst_first_owner", 32'(first_g), 32'(4'b0001));

    // Random traffic against the reference model.
    do_reset();
    repeat (900) begin
      for (int i = 0; i < N; i++) begin
        if (srcq[i].size() == 0 && $urandom_range(0, 3) == 0) begin
          len = $urandom_range(1, 20);
          for (int k = 0; k < len; k++) srcq[i].push_back({(k == len - 1) ? 1'b1 : 1'b0, 8'($urandom)});
        end
        en[i] = ($urandom_range(0, 9) != 0);
      end
      full_s = ($urandom_range(0, 4) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
